// File: rtl/fifo_multi.sv
// Multi-lane show-ahead FIFO: up to NUM_IN writes and NUM_OUT reads per cycle, zero-latency head view.
// Inserts visible one cycle after write; OUT_ready is derived from registered count only (no same-cycle credit).
module fifo_multi #(
   parameter int WIDTH   = 32,
   parameter int NUM     = 8,
   parameter int NUM_IN  = 2,
   parameter int NUM_OUT = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        IN_flush,
   input  logic [NUM_IN-1:0]           IN_valid,
   input  logic [NUM_IN*WIDTH-1:0]     IN_data,
   output logic                        OUT_ready,
   output logic [NUM_OUT-1:0]          OUT_valid,
   output logic [NUM_OUT*WIDTH-1:0]    OUT_data,
   input  logic [NUM_OUT-1:0]          IN_ready,
   output logic [$clog2(NUM):0]        free
);

   localparam int IW = $clog2(NUM);
   localparam int CW = IW + 1;

   logic [WIDTH-1:0] mem [NUM];
   logic [IW-1:0]    index_in;
   logic [IW-1:0]    index_out;
   logic [CW-1:0]    count;
   logic [CW-1:0]    n_in;
   logic [CW-1:0]    n_out;

   assign OUT_ready = (count <= CW'(NUM - NUM_IN));
   assign free      = CW'(NUM) - count;

   for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
      assign OUT_valid[g]              = (count > CW'(g));
      assign OUT_data[g*WIDTH +: WIDTH] = mem[index_out + IW'(g)];
   end

   // Only an unbroken run of valid lanes starting at lane 0 is accepted.
   always_comb begin
      logic stop;
      n_in = '0;
      stop = 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (!stop && IN_valid[i]) n_in = n_in + CW'(1);
         else                      stop = 1'b1;
      end
      if (!OUT_ready) n_in = '0;
   end

   always_comb begin
      logic stop;
      n_out = '0;
      stop  = 1'b0;
      for (int i = 0; i < NUM_OUT; i++) begin
         if (!stop && IN_ready[i] && OUT_valid[i]) n_out = n_out + CW'(1);
         else                                      stop  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !IN_flush) begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (CW'(i) < n_in) mem[index_in + IW'(i)] <= IN_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || IN_flush) begin
         index_in  <= '0;
         index_out <= '0;
         count     <= '0;
      end else begin
         index_in  <= index_in + n_in[IW-1:0];
         index_out <= index_out + n_out[IW-1:0];
         count     <= count + n_in - n_out;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (count <= CW'(NUM));
         assert (n_out <= count);
         assert ((CW+1)'(count) + (CW+1)'(n_in) <= (CW+1)'(NUM));
      end
   end

endmodule

// File: tb/tb_fifo_multi.sv
// Bench for fifo_multi: directed vector table, stream/wrap sequence, then random traffic vs a queue model.
module tb_fifo_multi;

   localparam int WIDTH   = 32;
   localparam int NUM     = 8;
   localparam int NUM_IN  = 2;
   localparam int NUM_OUT = 2;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      IN_flush;
   logic [NUM_IN-1:0]         IN_valid;
   logic [NUM_IN*WIDTH-1:0]   IN_data;
   logic                      OUT_ready;
   logic [NUM_OUT-1:0]        OUT_valid;
   logic [NUM_OUT*WIDTH-1:0]  OUT_data;
   logic [NUM_OUT-1:0]        IN_ready;
   logic [$clog2(NUM):0]      free;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mq[$];

   always #5 clk = ~clk;

   fifo_multi #(.WIDTH(WIDTH), .NUM(NUM), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT)) dut (
      .clk(clk), .rst(rst), .IN_flush(IN_flush), .IN_valid(IN_valid), .IN_data(IN_data),
      .OUT_ready(OUT_ready), .OUT_valid(OUT_valid), .OUT_data(OUT_data),
      .IN_ready(IN_ready), .free(free)
   );

   typedef struct {
      logic        r;
      logic        f;
      logic [1:0]  v;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [1:0]  rd;
      int          e_free;
      logic [1:0]  e_valid;
      logic        e_ready;
      logic [31:0] e0;
      logic [31:0] e1;
   } vec_t;

   vec_t tbl[19];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a queue of entries; insert/extract computed from lane prefixes.
   task automatic model_step(input logic r, input logic f, input logic [1:0] v,
                             input logic [63:0] d, input logic [1:0] rd);
      int sz, ni, no;
      if (r || f) begin
         mq.delete();
      end else begin
         sz = mq.size();
         ni = 0;
         no = 0;
         if (sz <= NUM - NUM_IN)
            while (ni < NUM_IN && v[ni]) ni++;
         while (no < NUM_OUT && no < sz && rd[no]) no++;
         repeat (no) void'(mq.pop_front());
         for (int k = 0; k < ni; k++) mq.push_back(d[k*32 +: 32]);
      end
   endtask

   task automatic model_check();
      int sz;
      sz = mq.size();
      chk("mdl_free", 64'(free), 64'(NUM - sz));
      chk("mdl_out_ready", 64'(OUT_ready), 64'(sz <= NUM - NUM_IN));
      for (int i = 0; i < NUM_OUT; i++) begin
         chk("mdl_out_valid", 64'(OUT_valid[i]), 64'(i < sz));
         if (i < sz) chk("mdl_out_data", 64'(OUT_data[i*WIDTH +: WIDTH]), 64'(mq[i]));
      end
   endtask

   // Called at negedge: drive, clock, advance model, sample at next negedge.
   task automatic cycle(input logic r, input logic f, input logic [1:0] v,
                        input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] rd);
      rst      = r;
      IN_flush = f;
      IN_valid = v;
      IN_data  = {d1, d0};
      IN_ready = rd;
      @(posedge clk);
      model_step(r, f, v, {d1, d0}, rd);
      @(negedge clk);
      model_check();
   endtask

   initial begin
      rst = 1'b1; IN_flush = 1'b0; IN_valid = '0; IN_data = '0; IN_ready = '0;

      //            r  f  v      d0     d1     rd     free val    rdy e0     e1
      tbl[0]  = '{1, 0, 2'b00, 32'h0, 32'h0, 2'b00, 8, 2'b00, 1, 32'h0, 32'h0};
      tbl[1]  = '{0, 0, 2'b11, 32'hA0, 32'hA1, 2'b00, 6, 2'b11, 1, 32'hA0, 32'hA1};
      tbl[2]  = '{0, 0, 2'b11, 32'hA2, 32'hA3, 2'b00, 4, 2'b11, 1, 32'hA0, 32'hA1};
      tbl[3]  = '{0, 0, 2'b11, 32'hA4, 32'hA5, 2'b00, 2, 2'b11, 1, 32'hA0, 32'hA1};
      tbl[4]  = '{0, 0, 2'b01, 32'hA6, 32'hEE, 2'b00, 1, 2'b11, 0, 32'hA0, 32'hA1};
      tbl[5]  = '{0, 0, 2'b11, 32'hA7, 32'hA8, 2'b00, 1, 2'b11, 0, 32'hA0, 32'hA1};
      tbl[6]  = '{0, 0, 2'b00, 32'h0, 32'h0, 2'b01, 2, 2'b11, 1, 32'hA1, 32'hA2};
      tbl[7]  = '{0, 0, 2'b10, 32'hC0, 32'hC1, 2'b00, 2, 2'b11, 1, 32'hA1, 32'hA2};
      tbl[8]  = '{0, 0, 2'b00, 32'h0, 32'h0, 2'b10, 2, 2'b11, 1, 32'hA1, 32'hA2};
      tbl[9]  = '{0, 0, 2'b00, 32'h0, 32'h0, 2'b11, 4, 2'b11, 1, 32'hA3, 32'hA4};
      tbl[10] = '{0, 0, 2'b01, 32'hA9, 32'h0, 2'b00, 3, 2'b11, 1, 32'hA3, 32'hA4};
      tbl[11] = '{0, 1, 2'b11, 32'hD0, 32'hD1, 2'b01, 8, 2'b00, 1, 32'h0, 32'h0};
      tbl[12] = '{0, 0, 2'b01, 32'hB0, 32'h0, 2'b00, 7, 2'b01, 1, 32'hB0, 32'h0};
      tbl[13] = '{0, 0, 2'b11, 32'hB1, 32'hB2, 2'b00, 5, 2'b11, 1, 32'hB0, 32'hB1};
      tbl[14] = '{0, 0, 2'b11, 32'hB3, 32'hB4, 2'b00, 3, 2'b11, 1, 32'hB0, 32'hB1};
      tbl[15] = '{0, 0, 2'b01, 32'hB5, 32'h0, 2'b00, 2, 2'b11, 1, 32'hB0, 32'hB1};
      tbl[16] = '{1, 1, 2'b11, 32'hE0, 32'hE1, 2'b11, 8, 2'b00, 1, 32'h0, 32'h0};
      tbl[17] = '{0, 0, 2'b11, 32'hF0, 32'hF1, 2'b00, 6, 2'b11, 1, 32'hF0, 32'hF1};
      tbl[18] = '{0, 0, 2'b00, 32'h0, 32'h0, 2'b01, 7, 2'b01, 1, 32'hF1, 32'h0};

      @(negedge clk);
      foreach (tbl[n]) begin
         cycle(tbl[n].r, tbl[n].f, tbl[n].v, tbl[n].d0, tbl[n].d1, tbl[n].rd);
         chk($sformatf("vec%0d_free", n), 64'(free), 64'(tbl[n].e_free));
         chk($sformatf("vec%0d_valid", n), 64'(OUT_valid), 64'(tbl[n].e_valid));
         chk($sformatf("vec%0d_ready", n), 64'(OUT_ready), 64'(tbl[n].e_ready));
         if (tbl[n].e_valid[0]) chk($sformatf("vec%0d_d0", n), 64'(OUT_data[31:0]), 64'(tbl[n].e0));
         if (tbl[n].e_valid[1]) chk($sformatf("vec%0d_d1", n), 64'(OUT_data[63:32]), 64'(tbl[n].e1));
      end

      // Steady stream across pointer wrap: after cycle k the head shows entries 2k, 2k+1.
      cycle(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 2'b00);
      for (int k = 0; k < 20; k++) begin
         cycle(1'b0, 1'b0, 2'b11, 32'(2*k), 32'(2*k+1), 2'b11);
         chk("stream_free", 64'(free), 64'(6));
         chk("stream_d0", 64'(OUT_data[31:0]), 64'(2*k));
         chk("stream_d1", 64'(OUT_data[63:32]), 64'(2*k+1));
      end

      // Random traffic with occasional flush and reset.
      for (int k = 0; k < 3000; k++) begin
         cycle($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
               2'($urandom), $urandom, $urandom, 2'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
